mips_mc_control: RTL

- Multicycle MIPS main control FSM.
- Drives the ALU's ALUControl code together with datapath mux selects and write enables.
- Consumes the ALU zero flag to resolve beq.
- Sits between the instruction register (opcode/funct) and the shared multicycle datapath: one ALU, one unified memory.

---
 rtl/mips_mc_control_if.sv | 33 +++
 rtl/mips_mc_control.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mips_mc_control_if.sv
// Control-to-datapath bundle for the multicycle MIPS control FSM.
// master = control unit (drives selects/enables), slave = datapath side.
interface mips_mc_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [1:0] ALUControl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       PCEn;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero,
        output ALUControl, ALUSrcA, ALUSrcB, PCSrc, IorD, MemWrite, IRWrite,
               RegDst, MemtoReg, RegWrite, PCEn, instr_done, illegal, state
    );

    modport slave (
        output opcode, funct, zero,
        input  ALUControl, ALUSrcA, ALUSrcB, PCSrc, IorD, MemWrite, IRWrite,
               RegDst, MemtoReg, RegWrite, PCEn, instr_done, illegal, state
    );
endinterface

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM: Moore-decoded datapath selects/enables.
// Latency 2-5 cycles per instruction (FETCH inclusive); no backpressure.
module mips_mc_control (
    input  logic               clk,
    input  logic               reset,
    mips_mc_control_if.master  bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;

    logic       funct_ok;
    logic [1:0] funct_alu;
    logic       pc_write, branch, mem_write, ir_write, reg_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = 2'b00;
        case (bus.funct)
            6'b100000: funct_alu = 2'b00;
            6'b100110: funct_alu = 2'b01;
            6'b100010: funct_alu = 2'b10;
            6'b101010: funct_alu = 2'b11;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = S_FETCH;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_ok) state_d = S_EXECUTE;
                        else          illegal_d = 1'b1;
                    end
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_ADDI: state_d = S_ADDIEX;
                    OP_J:    state_d = S_JUMP;
                    default: illegal_d = 1'b1;
                endcase
            end
            S_MEMADR:  state_d = (bus.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        bus.ALUControl = 2'b00;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.PCSrc      = 2'b00;
        bus.IorD       = 1'b0;
        bus.RegDst     = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.instr_done = 1'b0;
        pc_write       = 1'b0;
        branch         = 1'b0;
        mem_write      = 1'b0;
        ir_write       = 1'b0;
        reg_write      = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.ALUSrcB = 2'b01;
                ir_write    = 1'b1;
                pc_write    = 1'b1;
            end
            S_DECODE: bus.ALUSrcB = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            S_MEMREAD: bus.IorD = 1'b1;
            S_MEMWB: begin
                bus.MemtoReg   = 1'b1;
                reg_write      = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                bus.IorD       = 1'b1;
                mem_write      = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_EXECUTE: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = funct_alu;
            end
            S_ALUWB: begin
                bus.RegDst     = 1'b1;
                reg_write      = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = 2'b10;
                bus.PCSrc      = 2'b01;
                branch         = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_ADDIWB: begin
                reg_write      = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_JUMP: begin
                bus.PCSrc      = 2'b10;
                pc_write       = 1'b1;
                bus.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset kills every architectural side effect in the same cycle it rises.
    assign bus.MemWrite = mem_write & ~reset;
    assign bus.IRWrite  = ir_write  & ~reset;
    assign bus.RegWrite = reg_write & ~reset;
    assign bus.PCEn     = (pc_write | (branch & bus.zero)) & ~reset;
    assign bus.illegal  = illegal_q;
    assign bus.state    = state_q;
endmodule
